// File: rtl/uart_report_arbiter.sv
// ---------------------------------------------------------------------------
// uart_report_arbiter
// Shares one byte-wide UART transmitter between two report sources. Channel 0
// carries the threshold echo, channel 1 carries tracker target coordinates.
// Each granted request is sent as one frame:
//   FF FE FD FC, channel ID, payload (MSB byte first), checksum
// where checksum = (ID + payload bytes) mod 256. Requests are served round-robin.
//
// Ports
//   i_clk          system clock
//   i_rst_n        synchronous reset, active low
//   i_req0/1       level request, held until the matching grant
//   i_data0/1      payload, sampled during the grant cycle
//   o_gnt0/1       one-cycle pulse: channel granted, payload latched
//   o_done0/1      one-cycle pulse: channel frame fully sent
//   o_tx_data      byte for the transmitter, held from o_tx_start to i_tx_done
//   o_tx_start     one-cycle pulse: start sending o_tx_data
//   i_tx_done      one-cycle pulse from the transmitter: byte finished
//   o_busy         high from the grant cycle until back in idle
//   o_timeout_err  one-cycle pulse: frame aborted, transmitter never answered
// ---------------------------------------------------------------------------
module uart_report_arbiter #(
    parameter int          LEN0      = 6,
    parameter int          LEN1      = 4,
    parameter logic [31:0] TO_CYCLES = 32'd100000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic [8*LEN0-1:0] i_data0,
    output logic              o_gnt0,
    output logic              o_done0,
    input  logic              i_req1,
    input  logic [8*LEN1-1:0] i_data1,
    output logic              o_gnt1,
    output logic              o_done1,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int          LMAX  = (LEN0 > LEN1) ? LEN0 : LEN1;
    localparam int          PW    = 8 * LMAX;
    localparam logic [31:0] LAST0 = 32'(LEN0 + 5);
    localparam logic [31:0] LAST1 = 32'(LEN1 + 5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t          r_state;
    logic            r_ch;
    logic            r_lastServed;
    logic [PW-1:0]   r_payload;
    logic [7:0]      r_id;
    logic [31:0]     r_last;
    logic [31:0]     r_idx;
    logic [7:0]      r_csum;
    logic [31:0]     r_timer;
    logic [7:0]      r_txData;
    logic            r_txStart;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_done0;
    logic            r_done1;
    logic            r_busy;
    logic            r_timeoutErr;

    logic [PW-1:0]   w_load0;
    logic [PW-1:0]   w_load1;
    logic            w_pickCh;
    logic            w_isSummed;
    logic [7:0]      w_nextCsum;

    // Both payloads are stored left-aligned in one shared register so that
    // payload byte 0 is always the top byte, whichever channel owns the frame.
    assign w_load0 = PW'(i_data0) << (8 * (LMAX - LEN0));
    assign w_load1 = PW'(i_data1) << (8 * (LMAX - LEN1));

    // On a tie the channel that was not served last wins; otherwise the lone
    // requester wins (req1 alone picks 1, req0 alone picks 0).
    assign w_pickCh = (i_req0 && i_req1) ? ~r_lastServed : i_req1;

    // The byte currently held on o_tx_data (index r_idx) joins the checksum
    // only if it is the ID or a payload byte.
    assign w_isSummed = (r_idx >= 32'd4) && (r_idx < r_last);
    assign w_nextCsum = w_isSummed ? (r_csum + r_txData) : r_csum;

    // Frame byte at a given index; the checksum byte uses the supplied
    // accumulator so the caller can pass the freshly updated value.
    function automatic logic [7:0] byteAt(input logic [31:0] idx,
                                          input logic [7:0]  id,
                                          input logic [PW-1:0] payload,
                                          input logic [7:0]  csum,
                                          input logic [31:0] lastIdx);
        int pos;
        pos = int'(idx) - 5;
        if (idx == 32'd0)         return 8'hFF;
        else if (idx == 32'd1)    return 8'hFE;
        else if (idx == 32'd2)    return 8'hFD;
        else if (idx == 32'd3)    return 8'hFC;
        else if (idx == 32'd4)    return id;
        else if (idx == lastIdx)  return csum;
        else                      return payload[PW-1-8*pos -: 8];
    endfunction

    // Main controller: arbitration, frame sequencing and the byte handshake.
    // Every output is a register; pulse outputs default low each cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ch         <= 1'b0;
            r_lastServed <= 1'b1;
            r_payload    <= '0;
            r_id         <= 8'h00;
            r_last       <= 32'd0;
            r_idx        <= 32'd0;
            r_csum       <= 8'h00;
            r_timer      <= 32'd0;
            r_txData     <= 8'h00;
            r_txStart    <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_txStart    <= 1'b0;
            r_timeoutErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_ch    <= w_pickCh;
                        r_gnt0  <= ~w_pickCh;
                        r_gnt1  <= w_pickCh;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Rotating priority here means an aborted frame also counts as served.
                    r_lastServed <= r_ch;
                    if (r_ch) begin
                        r_payload <= w_load1;
                        r_id      <= 8'h01;
                        r_last    <= LAST1;
                    end else begin
                        r_payload <= w_load0;
                        r_id      <= 8'h00;
                        r_last    <= LAST0;
                    end
                    r_idx     <= 32'd0;
                    r_csum    <= 8'h00;
                    r_timer   <= 32'd0;
                    r_txData  <= 8'hFF;
                    r_txStart <= 1'b1;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    r_timer <= 32'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (r_idx == r_last) begin
                            r_done0 <= ~r_ch;
                            r_done1 <= r_ch;
                            r_state <= S_FINISH;
                        end else begin
                            r_idx     <= r_idx + 32'd1;
                            r_csum    <= w_nextCsum;
                            r_txData  <= byteAt(r_idx + 32'd1, r_id, r_payload, w_nextCsum, r_last);
                            r_txStart <= 1'b1;
                            r_state   <= S_SEND;
                        end
                    end else if (r_timer == TO_CYCLES - 32'd1) begin
                        r_timeoutErr <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt0        = r_gnt0;
    assign o_gnt1        = r_gnt1;
    assign o_done0       = r_done0;
    assign o_done1       = r_done1;
    assign o_tx_data     = r_txData;
    assign o_tx_start    = r_txStart;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_uart_report_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_report_arbiter
// Drives the arbiter with directed frame requests and a simple transmitter
// model that answers each tx_start with tx_done a fixed number of cycles later.
// Expected frame bytes are hand-computed constants in the vector table.
// ---------------------------------------------------------------------------
module tb_uart_report_arbiter;

    localparam int LEN0 = 6;
    localparam int LEN1 = 4;
    localparam int TO   = 1000;

    typedef struct {
        string       name;
        logic        req0;
        logic        req1;
        logic [47:0] data0;
        logic [31:0] data1;
        int          nBytes;
        logic [7:0]  exp [12];
        int          ch;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        req0    = 1'b0;
    logic        req1    = 1'b0;
    logic        tx_done = 1'b0;
    logic [47:0] data0   = '0;
    logic [31:0] data1   = '0;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [7:0]  txData;
    logic        tx_start;
    logic        busy;
    logic        timeoutErr;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs [4];

    logic [7:0] capQ [$];
    int         doneQ [$];
    int         gnt0Cnt, gnt1Cnt, done0Cnt, done1Cnt, toCnt;
    int         overlapErr = 0, gntBothErr = 0, stableErr = 0;
    int         cyc = 0, startCyc = 0, toCyc = 0;
    logic       outstanding = 1'b0;
    logic [7:0] heldByte = 8'h00;
    bit         txEnable = 1'b1;
    int         txDelay  = 10;

    always #5 clk = ~clk;

    uart_report_arbiter #(
        .LEN0      (LEN0),
        .LEN1      (LEN1),
        .TO_CYCLES (32'd1000)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req0        (req0),
        .i_data0       (data0),
        .o_gnt0        (gnt0),
        .o_done0       (done0),
        .i_req1        (req1),
        .i_data1       (data1),
        .o_gnt1        (gnt1),
        .o_done1       (done1),
        .o_tx_data     (txData),
        .o_tx_start    (tx_start),
        .i_tx_done     (tx_done),
        .o_busy        (busy),
        .o_timeout_err (timeoutErr)
    );

    // Transmitter model: after seeing tx_start it raises tx_done txDelay
    // cycles later for exactly one cycle. Driven just after the rising edge.
    initial begin
        forever begin
            if (tx_start === 1'b1 && txEnable) begin
                repeat (txDelay - 1) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    end

    // Monitor on the falling edge: captures transmitted bytes and pulse
    // counts, and tracks handshake rules (no new tx_start while a byte is
    // outstanding, tx_data steady while waiting, grants never both high).
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                outstanding = 1'b0;
            end else begin
                if (gnt0 && gnt1) gntBothErr++;
                if (gnt0)  gnt0Cnt++;
                if (gnt1)  gnt1Cnt++;
                if (done0) begin done0Cnt++; doneQ.push_back(0); end
                if (done1) begin done1Cnt++; doneQ.push_back(1); end
                if (tx_start) begin
                    if (outstanding) overlapErr++;
                    outstanding = 1'b1;
                    heldByte    = txData;
                    capQ.push_back(txData);
                    startCyc    = cyc;
                end else if (outstanding) begin
                    if (txData !== heldByte) stableErr++;
                    if (tx_done) outstanding = 1'b0;
                end
                if (timeoutErr) begin
                    toCnt++;
                    toCyc       = cyc;
                    outstanding = 1'b0;
                end
            end
        end
    end

    task automatic clearMon();
        capQ.delete();
        doneQ.delete();
        gnt0Cnt  = 0;
        gnt1Cnt  = 0;
        done0Cnt = 0;
        done1Cnt = 0;
        toCnt    = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Compares the captured bytes starting at base against table entry vi.
    task automatic checkBytes(input string tag, input int base, input int vi);
        for (int i = 0; i < vecs[vi].nBytes; i++) begin
            if (base + i < capQ.size())
                checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, capQ[base + i]}, {24'h0, vecs[vi].exp[i]});
            else
                checkOutput($sformatf("%s_byte%0d_missing", tag, i), 32'hDEAD, {24'h0, vecs[vi].exp[i]});
        end
    endtask

    // Raises the requests, drops them on the grant, optionally scrambles the
    // payload the cycle after the grant, then waits for done or timeout.
    task automatic applyStimulus(input logic r0, input logic r1, input logic [47:0] d0,
                                 input logic [31:0] d1, input bit scramble,
                                 input int budget, output bit finished);
        bit granted;
        finished = 1'b0;
        granted  = 1'b0;
        @(negedge clk);
        data0 = d0;
        data1 = d1;
        req0  = r0;
        req1  = r1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                granted = 1'b1;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!granted) begin
            checkOutput("grant_wait", 32'd0, 32'd1);
            return;
        end
        if (scramble) begin
            @(negedge clk);
            data0 = ~d0;
            data1 = ~d1;
        end
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done0 || done1 || timeoutErr) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) checkOutput("frame_wait", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Directed test sequence.
    initial begin
        bit fin;
        int nd;

        vecs[0].name = "ch0_mixed"; vecs[0].req0 = 1; vecs[0].req1 = 0;
        vecs[0].data0 = 48'h6975_82EB_00FF; vecs[0].data1 = 32'h0; vecs[0].nBytes = 12; vecs[0].ch = 0;
        vecs[0].exp = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h00, 8'h69, 8'h75, 8'h82, 8'hEB, 8'h00, 8'hFF, 8'h4A};
        vecs[1].name = "ch1_coords"; vecs[1].req0 = 0; vecs[1].req1 = 1;
        vecs[1].data0 = 48'h0; vecs[1].data1 = 32'h0140_00F0; vecs[1].nBytes = 10; vecs[1].ch = 1;
        vecs[1].exp = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h01, 8'h01, 8'h40, 8'h00, 8'hF0, 8'h32, 8'h00, 8'h00};
        vecs[2].name = "ch0_allff_wrap"; vecs[2].req0 = 1; vecs[2].req1 = 0;
        vecs[2].data0 = 48'hFFFF_FFFF_FFFF; vecs[2].data1 = 32'h0; vecs[2].nBytes = 12; vecs[2].ch = 0;
        vecs[2].exp = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFA};
        vecs[3].name = "ch1_zero"; vecs[3].req0 = 0; vecs[3].req1 = 1;
        vecs[3].data0 = 48'h0; vecs[3].data1 = 32'h0; vecs[3].nBytes = 10; vecs[3].ch = 1;
        vecs[3].exp = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};

        clearMon();
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_start", {31'h0, tx_start}, 32'd0);
        checkOutput("rst_tx_data", {24'h0, txData}, 32'd0);
        checkOutput("rst_busy", {31'h0, busy}, 32'd0);
        checkOutput("rst_gnt", {30'h0, gnt1, gnt0}, 32'd0);
        checkOutput("rst_done", {30'h0, done1, done0}, 32'd0);
        checkOutput("rst_timeout", {31'h0, timeoutErr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] table-driven single frames");
        for (int v = 0; v < 4; v++) begin
            clearMon();
            applyStimulus(vecs[v].req0, vecs[v].req1, vecs[v].data0, vecs[v].data1, 1'b0, 400, fin);
            checkOutput({vecs[v].name, "_count"}, capQ.size(), vecs[v].nBytes);
            checkBytes(vecs[v].name, 0, v);
            checkOutput({vecs[v].name, "_gnt0"}, gnt0Cnt, (vecs[v].ch == 0) ? 1 : 0);
            checkOutput({vecs[v].name, "_gnt1"}, gnt1Cnt, (vecs[v].ch == 1) ? 1 : 0);
            checkOutput({vecs[v].name, "_done0"}, done0Cnt, (vecs[v].ch == 0) ? 1 : 0);
            checkOutput({vecs[v].name, "_done1"}, done1Cnt, (vecs[v].ch == 1) ? 1 : 0);
            checkOutput({vecs[v].name, "_busy_after"}, {31'h0, busy}, 32'd0);
            checkOutput({vecs[v].name, "_timeouts"}, toCnt, 32'd0);
        end

        $display("[TB] payload change after grant");
        clearMon();
        applyStimulus(1'b1, 1'b0, vecs[0].data0, 32'h0, 1'b1, 400, fin);
        checkOutput("hold_count", capQ.size(), 32'd12);
        checkBytes("hold", 0, 0);

        $display("[TB] transmitter silent, timeout abort");
        clearMon();
        txEnable = 1'b0;
        applyStimulus(1'b1, 1'b0, vecs[0].data0, 32'h0, 1'b0, TO + 200, fin);
        checkOutput("to_count", capQ.size(), 32'd1);
        if (capQ.size() > 0) checkOutput("to_first_byte", {24'h0, capQ[0]}, 32'hFF);
        checkOutput("to_pulses", toCnt, 32'd1);
        checkOutput("to_done0", done0Cnt, 32'd0);
        checkOutput("to_busy", {31'h0, busy}, 32'd0);
        // WAIT starts the cycle after tx_start and lasts TO cycles; the pulse follows.
        checkOutput("to_delay", toCyc - startCyc, TO + 1);
        txEnable = 1'b1;
        clearMon();
        applyStimulus(1'b0, 1'b1, 48'h0, vecs[1].data1, 1'b0, 400, fin);
        checkOutput("after_to_count", capQ.size(), 32'd10);
        checkBytes("after_to", 0, 1);
        checkOutput("after_to_done1", done1Cnt, 32'd1);

        $display("[TB] reset during WAIT of byte 5");
        clearMon();
        @(negedge clk);
        data0 = vecs[0].data0;
        req0  = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (gnt0) break;
        end
        req0 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (capQ.size() >= 6) break;
        end
        checkOutput("rst5_reached", capQ.size(), 32'd6);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst5_tx_start", {31'h0, tx_start}, 32'd0);
        checkOutput("rst5_tx_data", {24'h0, txData}, 32'd0);
        checkOutput("rst5_busy", {31'h0, busy}, 32'd0);
        checkOutput("rst5_gnt", {30'h0, gnt1, gnt0}, 32'd0);
        checkOutput("rst5_done_to", {29'h0, timeoutErr, done1, done0}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("rst5_no_done", done0Cnt, 32'd0);
        clearMon();
        applyStimulus(1'b1, 1'b0, vecs[0].data0, 32'h0, 1'b0, 400, fin);
        checkOutput("rst5_restart_count", capQ.size(), 32'd12);
        checkBytes("rst5_restart", 0, 0);

        $display("[TB] both requests held from reset release");
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = vecs[0].data0;
        data1 = vecs[1].data1;
        repeat (2) @(negedge clk);
        clearMon();
        rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (done0 || done1) nd++;
            if (nd == 4) break;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rr_done_count", doneQ.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < doneQ.size()) checkOutput($sformatf("rr_order%0d", i), doneQ[i], i % 2);
        end
        checkOutput("rr_gnt0", gnt0Cnt, 32'd2);
        checkOutput("rr_gnt1", gnt1Cnt, 32'd2);
        checkOutput("rr_bytes", capQ.size(), 32'd44);
        checkBytes("rr_f0", 0, 0);
        checkBytes("rr_f1", 12, 1);
        checkBytes("rr_f2", 22, 0);
        checkBytes("rr_f3", 34, 1);
        checkOutput("rr_busy_after", {31'h0, busy}, 32'd0);

        checkOutput("gnt_one_hot", gntBothErr, 32'd0);
        checkOutput("tx_start_overlap", overlapErr, 32'd0);
        checkOutput("tx_data_stable", stableErr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
